// File: rtl/mm_seg7_display.sv
// Drives the Basys3 4-digit multiplexed 7-segment display from a 4-digit BCD value.
// New values are applied only at frame boundaries, and each digit slot starts with a short blanking guard.
module mm_seg7_display #(
  parameter int REFRESH_DIV = 100_000,
  parameter int GUARD_CYC   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic [15:0] din_bcd_i,
  input  logic        din_update_i,
  input  logic        lzb_en_i,
  input  logic        dp_en_i,
  input  logic [1:0]  dp_pos_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_upd_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'(GUARD_CYC);

  logic [CNT_W-1:0] slot_cnt;
  logic [1:0]       digit_idx;
  logic [15:0]      disp_reg;
  logic [15:0]      pend_reg;
  logic             pend_valid;

  logic             slot_wrap;
  logic             frame_end;
  logic             commit;
  logic             in_guard;
  logic [3:0]       cur_nib;
  logic [3:0]       zero_nib;
  logic [3:0]       blank_vec;
  logic             cur_blank;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;

  function automatic logic [6:0] decode_bcd(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
    return pat;
  endfunction

  assign slot_wrap = (slot_cnt == CNT_MAX);
  assign frame_end = slot_wrap && (digit_idx == 2'd3);
  assign commit    = frame_end && (din_update_i || pend_valid);
  assign in_guard  = (slot_cnt < GUARD_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (slot_wrap) begin
      slot_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      slot_cnt  <= slot_cnt + 1'b1;
    end
  end

  // A strobe landing exactly on the frame boundary is committed directly and beats any pending value.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_reg   <= 16'h0000;
      pend_reg   <= 16'h0000;
      pend_valid <= 1'b0;
    end else if (clr_i) begin
      disp_reg   <= 16'h0000;
      pend_reg   <= 16'h0000;
      pend_valid <= 1'b0;
    end else if (frame_end && din_update_i) begin
      disp_reg   <= din_bcd_i;
      pend_valid <= 1'b0;
    end else if (frame_end && pend_valid) begin
      disp_reg   <= pend_reg;
      pend_valid <= 1'b0;
    end else if (din_update_i) begin
      pend_reg   <= din_bcd_i;
      pend_valid <= 1'b1;
    end
  end

  always_comb begin
    cur_nib = disp_reg[3:0];
    case (digit_idx)
      2'd0: cur_nib = disp_reg[3:0];
      2'd1: cur_nib = disp_reg[7:4];
      2'd2: cur_nib = disp_reg[11:8];
      2'd3: cur_nib = disp_reg[15:12];
      default: cur_nib = disp_reg[3:0];
    endcase
  end

  // A digit is a leading zero only if it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    zero_nib[0]  = (disp_reg[3:0]   == 4'd0);
    zero_nib[1]  = (disp_reg[7:4]   == 4'd0);
    zero_nib[2]  = (disp_reg[11:8]  == 4'd0);
    zero_nib[3]  = (disp_reg[15:12] == 4'd0);
    blank_vec[3] = lzb_en_i && zero_nib[3];
    blank_vec[2] = blank_vec[3] && zero_nib[2];
    blank_vec[1] = blank_vec[2] && zero_nib[1];
    blank_vec[0] = 1'b0;
    cur_blank    = blank_vec[digit_idx];
  end

  always_comb begin
    an_nxt  = 4'hF;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (!in_guard) begin
      an_nxt  = ~(4'b0001 << digit_idx);
      seg_nxt = cur_blank ? 7'h7F : decode_bcd(cur_nib);
      dp_nxt  = ~(dp_en_i && (digit_idx == dp_pos_i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_o        <= 4'hF;
      seg_o       <= 7'h7F;
      dp_o        <= 1'b1;
      frame_upd_o <= 1'b0;
    end else begin
      an_o        <= an_nxt;
      seg_o       <= seg_nxt;
      dp_o        <= dp_nxt;
      frame_upd_o <= commit && !clr_i;
    end
  end

endmodule
